// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_bank_pkg: shared definitions for the SPI register bank.
//   Register offsets (addr[4:0]), CTRL/STATUS bit positions, BAUD reset
//   default and the bus FSM state type.
package spi_reg_bank_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_BAUD   = 5'h04;
  localparam logic [4:0] REG_STATUS = 5'h08;
  localparam logic [4:0] REG_TXDATA = 5'h0C;
  localparam logic [4:0] REG_RXDATA = 5'h10;

  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_CPOL      = 1;
  localparam int unsigned CTRL_CPHA      = 2;
  localparam int unsigned CTRL_LSB_FIRST = 3;
  localparam int unsigned CTRL_TX_IE     = 5;
  localparam int unsigned CTRL_RX_IE     = 6;
  localparam int unsigned CTRL_TX_CLR    = 8;
  localparam int unsigned CTRL_RX_CLR    = 9;

  localparam int unsigned STATUS_TX_EMPTY   = 0;
  localparam int unsigned STATUS_TX_FULL    = 1;
  localparam int unsigned STATUS_RX_EMPTY   = 2;
  localparam int unsigned STATUS_RX_FULL    = 3;
  localparam int unsigned STATUS_RX_OVERRUN = 4;

  localparam logic [15:0] BAUD_RESET_DEFAULT = 16'h0004;

  typedef enum logic {
    BUS_IDLE,
    BUS_DONE
  } bus_state_e;

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: select/ready register bus between the APB front-end
// (master) and the SPI register bank (slave).
//   bus_addr_in/bus_sel_in/bus_write_in/bus_wdata_in : master -> slave
//   bus_rdata_out/bus_ready_out/bus_error_out         : slave -> master
interface spi_reg_bank_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] bus_addr_in;
  logic                  bus_sel_in;
  logic                  bus_write_in;
  logic [DATA_WIDTH-1:0] bus_wdata_in;
  logic [DATA_WIDTH-1:0] bus_rdata_out;
  logic                  bus_ready_out;
  logic                  bus_error_out;

  modport master (
    output bus_addr_in, bus_sel_in, bus_write_in, bus_wdata_in,
    input  bus_rdata_out, bus_ready_out, bus_error_out
  );

  modport slave (
    input  bus_addr_in, bus_sel_in, bus_write_in, bus_wdata_in,
    output bus_rdata_out, bus_ready_out, bus_error_out
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: 8-bit synchronous FIFO used for the SPI TX and RX paths.
//   apb_clk_in, apb_rstn_in : clock, async active-low reset
//   push/push_data          : write request (refused when full)
//   pop                     : read request (ignored when empty)
//   clr                     : empties the FIFO, overrides push/pop
//   head                    : entry at the read pointer
//   full/empty/count        : occupancy, all from the current count
module spi_sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          apb_clk_in,
  input  logic          apb_rstn_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          clr,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed when non-empty.
  always_ff @(posedge apb_clk_in) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI configuration registers, TX/RX byte FIFOs, sticky
// status and level interrupt behind a one-access-per-select register bus.
//   apb_clk_in, apb_rstn_in      : clock, async active-low reset
//   bus (spi_reg_bank_if.slave)  : select/ready bus; ready/error/rdata one
//                                  cycle after select, for one cycle
//   tx_data_out/tx_valid_out     : TX FIFO head to shift engine
//   tx_ready_in                  : engine pop strobe
//   rx_data_in/rx_valid_in       : received byte push strobe
//   cfg_*_out                    : CTRL and BAUD fields
//   irq_out                      : level interrupt
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = BAUD_RESET_DEFAULT
) (
  input  logic              apb_clk_in,
  input  logic              apb_rstn_in,
  spi_reg_bank_if.slave     bus,
  output logic [7:0]        tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_valid_in,
  output logic              cfg_enable_out,
  output logic              cfg_cpol_out,
  output logic              cfg_cpha_out,
  output logic              cfg_lsb_first_out,
  output logic [15:0]       cfg_baud_div_out,
  output logic              irq_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [4:0]            off;

  bus_state_e            state;
  logic                  ready_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  tx_ie_q;
  logic                  rx_ie_q;
  logic                  rx_overrun_q;

  logic                  access;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic                  wr_ctrl;
  logic                  wr_baud;
  logic                  w1c_ovr;
  logic                  tx_push;
  logic                  rx_pop;
  logic                  tx_pop;
  logic                  tx_clr;
  logic                  rx_clr;

  logic [7:0]            tx_head;
  logic [7:0]            rx_head;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]         unused_tx_count;
  logic [CW-1:0]         unused_rx_count;
  logic                  unused_bits;

  logic [6:0]            ctrl_rd;
  logic [4:0]            status_rd;

  assign addr        = bus.bus_addr_in;
  assign wdata       = bus.bus_wdata_in;
  assign off         = addr[4:0];
  assign unused_bits = ^{addr[ADDR_WIDTH-1:5], wdata[DATA_WIDTH-1:16]};

  assign bus.bus_ready_out = ready_q;
  assign bus.bus_error_out = error_q;
  assign bus.bus_rdata_out = rdata_q;

  assign ctrl_rd   = {rx_ie_q, tx_ie_q, 1'b0, cfg_lsb_first_out,
                      cfg_cpha_out, cfg_cpol_out, cfg_enable_out};
  assign status_rd = {rx_overrun_q, rx_full, rx_empty, tx_full, tx_empty};

  assign access = (state == BUS_IDLE) && bus.bus_sel_in;
  assign tx_pop = tx_valid_out && tx_ready_in;
  assign tx_clr = wr_ctrl && wdata[CTRL_TX_CLR];
  assign rx_clr = wr_ctrl && wdata[CTRL_RX_CLR];

  // Decode: every side effect is gated by access, so an erroring access
  // has none.
  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = '0;
    wr_ctrl   = 1'b0;
    wr_baud   = 1'b0;
    w1c_ovr   = 1'b0;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    if (access) begin
      if (off[1:0] != 2'b00) begin
        acc_err = 1'b1;
      end else begin
        case (off)
          REG_CTRL: begin
            if (bus.bus_write_in) wr_ctrl = 1'b1;
            else                  acc_rdata[6:0] = ctrl_rd;
          end
          REG_BAUD: begin
            if (bus.bus_write_in) wr_baud = 1'b1;
            else                  acc_rdata[15:0] = cfg_baud_div_out;
          end
          REG_STATUS: begin
            if (bus.bus_write_in) w1c_ovr = wdata[STATUS_RX_OVERRUN];
            else                  acc_rdata[4:0] = status_rd;
          end
          REG_TXDATA: begin
            if (!bus.bus_write_in || tx_full) acc_err = 1'b1;
            else                              tx_push = 1'b1;
          end
          REG_RXDATA: begin
            if (bus.bus_write_in || rx_empty) begin
              acc_err = 1'b1;
            end else begin
              rx_pop          = 1'b1;
              acc_rdata[7:0]  = rx_head;
            end
          end
          default: acc_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state             <= BUS_IDLE;
      ready_q           <= 1'b0;
      error_q           <= 1'b0;
      rdata_q           <= '0;
      cfg_enable_out    <= 1'b0;
      cfg_cpol_out      <= 1'b0;
      cfg_cpha_out      <= 1'b0;
      cfg_lsb_first_out <= 1'b0;
      tx_ie_q           <= 1'b0;
      rx_ie_q           <= 1'b0;
      cfg_baud_div_out  <= BAUD_RESET;
      rx_overrun_q      <= 1'b0;
    end else begin
      // A same-cycle overrun wins over the write-1-to-clear.
      rx_overrun_q <= (rx_overrun_q && !w1c_ovr) || (rx_valid_in && rx_full);
      case (state)
        BUS_IDLE: begin
          if (bus.bus_sel_in) begin
            ready_q <= 1'b1;
            error_q <= acc_err;
            rdata_q <= acc_rdata;
            state   <= BUS_DONE;
            if (wr_ctrl) begin
              cfg_enable_out    <= wdata[CTRL_ENABLE];
              cfg_cpol_out      <= wdata[CTRL_CPOL];
              cfg_cpha_out      <= wdata[CTRL_CPHA];
              cfg_lsb_first_out <= wdata[CTRL_LSB_FIRST];
              tx_ie_q           <= wdata[CTRL_TX_IE];
              rx_ie_q           <= wdata[CTRL_RX_IE];
            end
            if (wr_baud) cfg_baud_div_out <= wdata[15:0];
          end
        end
        BUS_DONE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
          if (!bus.bus_sel_in) state <= BUS_IDLE;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

  spi_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .apb_clk_in  (apb_clk_in),
    .apb_rstn_in (apb_rstn_in),
    .push        (tx_push),
    .push_data   (wdata[7:0]),
    .pop         (tx_pop),
    .clr         (tx_clr),
    .head        (tx_head),
    .full        (tx_full),
    .empty       (tx_empty),
    .count       (unused_tx_count)
  );

  spi_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .apb_clk_in  (apb_clk_in),
    .apb_rstn_in (apb_rstn_in),
    .push        (rx_valid_in),
    .push_data   (rx_data_in),
    .pop         (rx_pop),
    .clr         (rx_clr),
    .head        (rx_head),
    .full        (rx_full),
    .empty       (rx_empty),
    .count       (unused_rx_count)
  );

  assign tx_valid_out = !tx_empty;
  assign tx_data_out  = tx_empty ? '0 : tx_head;
  assign irq_out      = (tx_ie_q && tx_empty) || (rx_ie_q && !rx_empty) ||
                        rx_overrun_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        cfg_en, cfg_cpol, cfg_cpha, cfg_lsb;
  logic [15:0] cfg_baud;
  logic        irq;

  always #5 clk = ~clk;

  spi_reg_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  spi_reg_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(DEPTH),
    .BAUD_RESET(16'h0004)
  ) dut (
    .apb_clk_in        (clk),
    .apb_rstn_in       (rst_n),
    .bus               (bus_if),
    .tx_data_out       (tx_data),
    .tx_valid_out      (tx_valid),
    .tx_ready_in       (tx_ready),
    .rx_data_in        (rx_data),
    .rx_valid_in       (rx_valid),
    .cfg_enable_out    (cfg_en),
    .cfg_cpol_out      (cfg_cpol),
    .cfg_cpha_out      (cfg_cpha),
    .cfg_lsb_first_out (cfg_lsb),
    .cfg_baud_div_out  (cfg_baud),
    .irq_out           (irq)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: registers as plain fields, FIFOs as queues.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [6:0]  m_ctrl = '0;
  logic [15:0] m_baud = 16'h0004;
  logic        m_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_ovr, rx_q.size() == DEPTH, rx_q.size() == 0,
            tx_q.size() == DEPTH, tx_q.size() == 0};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[5] && tx_q.size() == 0) || (m_ctrl[6] && rx_q.size() != 0) || m_ovr;
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = '0;
    m_baud = 16'h0004;
    m_ovr  = 1'b0;
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rx_same, input logic [7:0] rx_byte,
                              output logic exp_err, output logic [31:0] exp_rd);
    logic [4:0] off;
    logic       rx_was_full;
    logic       rx_cleared;
    off         = addr[4:0];
    rx_was_full = (rx_q.size() == DEPTH);
    rx_cleared  = 1'b0;
    exp_err     = 1'b0;
    exp_rd      = '0;
    if (off[1:0] != 2'b00) exp_err = 1'b1;
    else case (off)
      5'h00: if (wr) begin
               m_ctrl = wdata[6:0] & 7'h6F;
               if (wdata[8]) tx_q.delete();
               if (wdata[9]) begin rx_q.delete(); rx_cleared = 1'b1; end
             end else exp_rd = {25'd0, m_ctrl};
      5'h04: if (wr) m_baud = wdata[15:0]; else exp_rd = {16'd0, m_baud};
      5'h08: if (wr) begin if (wdata[4]) m_ovr = 1'b0; end else exp_rd = m_status();
      5'h0C: if (!wr || tx_q.size() == DEPTH) exp_err = 1'b1; else tx_q.push_back(wdata[7:0]);
      5'h10: if (wr || rx_q.size() == 0) exp_err = 1'b1;
             else exp_rd = {24'd0, rx_q.pop_front()};
      default: exp_err = 1'b1;
    endcase
    if (rx_same) begin
      if (rx_was_full) m_ovr = 1'b1;
      else if (!rx_cleared) rx_q.push_back(rx_byte);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".en"},   32'(cfg_en),   32'(m_ctrl[0]));
    chk({tag, ".cpol"}, 32'(cfg_cpol), 32'(m_ctrl[1]));
    chk({tag, ".cpha"}, 32'(cfg_cpha), 32'(m_ctrl[2]));
    chk({tag, ".lsb"},  32'(cfg_lsb),  32'(m_ctrl[3]));
    chk({tag, ".baud"}, 32'(cfg_baud), 32'(m_baud));
    chk({tag, ".irq"},  32'(irq),      32'(m_irq()));
    chk({tag, ".txv"},  32'(tx_valid), 32'(tx_q.size() != 0));
    chk({tag, ".txd"},  32'(tx_data),  (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'd0);
  endtask

  task automatic bus_op(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rx_same, input logic [7:0] rx_byte);
    logic        exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    bus_if.bus_sel_in   = 1'b1;
    bus_if.bus_write_in = wr;
    bus_if.bus_addr_in  = addr;
    bus_if.bus_wdata_in = wdata;
    rx_valid = rx_same;
    rx_data  = rx_byte;
    model_access(wr, addr, wdata, rx_same, rx_byte, exp_err, exp_rd);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk({tag, ".ready"}, 32'(bus_if.bus_ready_out), 32'd1);
    chk({tag, ".error"}, 32'(bus_if.bus_error_out), 32'(exp_err));
    chk({tag, ".rdata"}, bus_if.bus_rdata_out, exp_rd);
    bus_if.bus_sel_in = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".ready_drop"}, 32'(bus_if.bus_ready_out), 32'd0);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (rx_q.size() == DEPTH) m_ovr = 1'b1;
    else rx_q.push_back(b);
  endtask

  task automatic tx_pop_cycle(input string tag);
    @(negedge clk);
    tx_ready = 1'b1;
    chk({tag, ".txv"}, 32'(tx_valid), 32'(tx_q.size() != 0));
    chk({tag, ".txd"}, 32'(tx_data), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned ready_cnt;
    logic [31:0] got_rd;
    logic [31:0] exp_rd;
    logic [4:0]  offs [9];
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h01, 5'h02, 5'h1F};

    bus_if.bus_sel_in   = 1'b0;
    bus_if.bus_write_in = 1'b0;
    bus_if.bus_addr_in  = '0;
    bus_if.bus_wdata_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(bus_if.bus_ready_out), 32'd0);
    chk("rst.error", 32'(bus_if.bus_error_out), 32'd0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    bus_op("rd_baud", 1'b0, 32'h04, 32'h0, 1'b0, 8'h00);
    bus_op("rd_status", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);
    chk("rst.status_const", 32'(m_status()), 32'h05);

    bus_op("wr_ctrl", 1'b1, 32'h00, 32'h0000_0027, 1'b0, 8'h00);
    check_outputs("cfg27");
    chk("cfg27.irq_const", 32'(irq), 32'd1);
    bus_op("rd_ctrl", 1'b0, 32'h00, 32'h0, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++)
      bus_op("tx_push", 1'b1, 32'h0C, 32'(8'hA1 + i), 1'b0, 8'h00);
    bus_op("tx_full_status", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) tx_pop_cycle("tx_drain");
    check_outputs("tx_empty");

    for (int i = 0; i < 5; i++) rx_push(8'(8'h11 + i));
    bus_op("rx_ovr_status", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);
    chk("rx_ovr_status_const", m_status(), 32'h19);
    for (int i = 0; i < 5; i++) bus_op("rx_read", 1'b0, 32'h10, 32'h0, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) rx_push(8'(8'h30 + i));
    bus_op("w1c_with_ovr", 1'b1, 32'h08, 32'h10, 1'b1, 8'h99);
    bus_op("ovr_kept", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);
    bus_op("w1c_plain", 1'b1, 32'h08, 32'h10, 1'b0, 8'h00);
    bus_op("ovr_cleared", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);

    // Select held high for 5 cycles on an RXDATA read.
    @(negedge clk);
    bus_if.bus_sel_in   = 1'b1;
    bus_if.bus_write_in = 1'b0;
    bus_if.bus_addr_in  = 32'h10;
    exp_rd    = {24'd0, rx_q[0]};
    ready_cnt = 0;
    got_rd    = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.bus_ready_out) begin
        ready_cnt++;
        got_rd = bus_if.bus_rdata_out;
      end
    end
    bus_if.bus_sel_in = 1'b0;
    void'(rx_q.pop_front());
    @(posedge clk);
    #1;
    chk("hold.ready_count", 32'(ready_cnt), 32'd1);
    chk("hold.rdata", got_rd, exp_rd);
    bus_op("hold.status", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);
    bus_op("hold.next_read", 1'b0, 32'h10, 32'h0, 1'b0, 8'h00);

    bus_op("bad_0x14", 1'b0, 32'h14, 32'h0, 1'b0, 8'h00);
    bus_op("bad_0x02", 1'b1, 32'h02, 32'h1, 1'b0, 8'h00);
    bus_op("rd_txdata", 1'b0, 32'h0C, 32'h0, 1'b0, 8'h00);
    bus_op("wr_rxdata", 1'b1, 32'h10, 32'h5A, 1'b0, 8'h00);

    // Reset while an erroring access sits in DONE.
    bus_op("pre_rst_push", 1'b1, 32'h0C, 32'h77, 1'b0, 8'h00);
    @(negedge clk);
    bus_if.bus_sel_in   = 1'b1;
    bus_if.bus_write_in = 1'b0;
    bus_if.bus_addr_in  = 32'h0C;
    @(posedge clk);
    #1;
    chk("done.error_before_rst", 32'(bus_if.bus_error_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ready", 32'(bus_if.bus_ready_out), 32'd0);
    chk("rst_mid.error", 32'(bus_if.bus_error_out), 32'd0);
    bus_if.bus_sel_in = 1'b0;
    model_reset();
    check_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    bus_op("rst_mid.status", 1'b0, 32'h08, 32'h0, 1'b0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        logic [31:0] a;
        logic [31:0] w;
        a = $urandom;
        a[4:0] = offs[$urandom_range(0, 8)];
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[9:8] = 2'b00;
        bus_op("rand_bus", 1'($urandom_range(0, 1)), a, w,
               1'($urandom_range(0, 3) == 0), 8'($urandom));
      end else if (r <= 6) begin
        rx_push(8'($urandom));
      end else if (r <= 8) begin
        tx_pop_cycle("rand_pop");
      end else begin
        @(negedge clk);
      end
      #1;
      check_outputs("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
